ex_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline; drives the MEM stage directly.

---
 rtl/ex_pkg.sv | 43 ++++
 rtl/ex_stage_mul_div.sv | 167 ++++++++++++++++
 rtl/ex_stage.sv | 143 ++++++++++++++
 tb/tb_ex_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - ALU op codes, forwarding selects and MD FSM encoding for the EX stage
// Contents:
//   OP_*     4-bit operation codes driven on ex_stage.alu_op
//   FWD_*    2-bit operand selects driven on ex_stage.forward_a/b
//   MD_*     state encoding of the iterative multiply/divide FSM
//   is_md_op helper that flags the multi-cycle operations
package ex_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD  = 4'd0;
  localparam alu_op_t OP_SUB  = 4'd1;
  localparam alu_op_t OP_AND  = 4'd2;
  localparam alu_op_t OP_OR   = 4'd3;
  localparam alu_op_t OP_XOR  = 4'd4;
  localparam alu_op_t OP_NOR  = 4'd5;
  localparam alu_op_t OP_SLT  = 4'd6;
  localparam alu_op_t OP_SLTU = 4'd7;
  localparam alu_op_t OP_SLL  = 4'd8;
  localparam alu_op_t OP_SRL  = 4'd9;
  localparam alu_op_t OP_SRA  = 4'd10;
  localparam alu_op_t OP_LUI  = 4'd11;
  localparam alu_op_t OP_MFHI = 4'd12;
  localparam alu_op_t OP_MFLO = 4'd13;
  // The 4-bit code space holds only two multi-cycle codes. MULT/DIV
  // instructions carry no shift amount, so the decoder sets shamt[0] to
  // select the unsigned form (MULTU/DIVU) and clears it for the signed form.
  localparam alu_op_t OP_MULT = 4'd14;
  localparam alu_op_t OP_DIV  = 4'd15;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  function automatic logic is_md_op(input alu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_stage_mul_div.sv
// rtl/ex_stage_mul_div.sv - iterative radix-2 multiply/divide unit owning HI/LO
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          MULT/DIV present in EX (only acted on in IDLE)
//   is_div         1: divide, 0: multiply
//   is_unsigned    1: MULTU/DIVU, 0: signed forms
//   op_a, op_b     forwarded operands, latched on start
//   busy           combinational stall request (start in IDLE, or BUSY)
//   done           high for the single DONE cycle
//   hi, lo         architectural HI/LO registers
module mul_div_unit #(
  parameter int DATA_W    = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  import ex_pkg::*;

  // Enough radix-2 steps per BUSY cycle to finish DATA_W bits in MD_CYCLES.
  localparam int STEPS = (DATA_W + MD_CYCLES - 1) / MD_CYCLES;
  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    count;
  logic [BIT_W-1:0]    bits_left;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   dividend;
  logic                div_mode;
  logic                neg_lo;
  logic                neg_hi;
  logic                zero_div;

  logic                sign_a;
  logic                sign_b;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [2*DATA_W-1:0] acc_next;
  logic [BIT_W-1:0]    bits_next;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  // The core works on magnitudes; signs are restored once in DONE.
  assign sign_a = !is_unsigned && op_a[DATA_W-1];
  assign sign_b = !is_unsigned && op_b[DATA_W-1];
  assign mag_a  = sign_a ? -op_a : op_a;
  assign mag_b  = sign_b ? -op_b : op_b;

  function automatic logic [2*DATA_W-1:0] md_step(input logic [2*DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0]   b,
                                                   input logic                div);
    logic [DATA_W:0]     part;
    logic [2*DATA_W-1:0] r;
    r = a;
    if (div) begin
      // Restoring division: shift next dividend bit into the remainder.
      part = {a[2*DATA_W-1:DATA_W], a[DATA_W-1]};
      r[DATA_W-1:0] = {a[DATA_W-2:0], 1'b0};
      if (part >= {1'b0, b}) begin
        part = part - {1'b0, b};
        r[0] = 1'b1;
      end
      r[2*DATA_W-1:DATA_W] = part[DATA_W-1:0];
    end else begin
      // Shift-add: the carry out of the upper half shifts back in from the top.
      part = {1'b0, a[2*DATA_W-1:DATA_W]} + (a[0] ? {1'b0, b} : {(DATA_W+1){1'b0}});
      r = {part, a[DATA_W-1:1]};
    end
    return r;
  endfunction

  always_comb begin
    acc_next  = acc;
    bits_next = bits_left;
    for (int i = 0; i < STEPS; i++) begin
      if (bits_next != '0) begin
        acc_next  = md_step(acc_next, opb, div_mode);
        bits_next = bits_next - BIT_W'(1);
      end
    end
  end

  always_comb begin
    prod   = neg_lo ? -acc : acc;
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (div_mode) begin
      if (zero_div) begin
        res_hi = dividend;
        res_lo = '1;
      end else begin
        res_lo = neg_lo ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        res_hi = neg_hi ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MD_IDLE;
      count     <= '0;
      bits_left <= '0;
      acc       <= '0;
      opb       <= '0;
      dividend  <= '0;
      div_mode  <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      zero_div  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state     <= MD_BUSY;
            count     <= CNT_W'(MD_CYCLES - 1);
            bits_left <= BIT_W'(DATA_W);
            acc       <= {{DATA_W{1'b0}}, mag_a};
            opb       <= mag_b;
            dividend  <= op_a;
            div_mode  <= is_div;
            // Product and quotient negate on differing signs; the
            // remainder follows the dividend.
            neg_lo    <= sign_a ^ sign_b;
            neg_hi    <= sign_a;
            zero_div  <= is_div && (op_b == '0);
          end
        end
        MD_BUSY: begin
          acc       <= acc_next;
          bits_left <= bits_next;
          if (count == '0) begin
            state <= MD_DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        MD_DONE: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // Gated by rst so the front end is released the instant reset asserts,
  // even while a MULT/DIV is still presented in EX.
  assign busy = !rst && (((state == MD_IDLE) && start) || (state == MD_BUSY));
  assign done = (state == MD_DONE);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding, ALU, MULT/DIV and EX/MEM register
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   control_wb_in, mem_read_in,
//   mem_write_in                   controls carried to MEM/WB
//   alu_op, alu_src, reg_dst       operation, B=imm select, dest=rd select
//   read_data_1/2, imm_ext, shamt  operands
//   rt, rd                         destination candidates
//   forward_a/b, mem_fwd_data,
//   wb_fwd_data                    forwarding selects and sources
//   *_out                          EX/MEM pipeline register
//   stall_out                      combinational freeze of PC, IF/ID, ID/EX
module ex_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int MD_CYCLES = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        control_wb_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [4:0]        shamt,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic [1:0]        control_wb_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              stall_out
);
  import ex_pkg::*;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              md_op;
  logic              md_busy;
  logic              md_done;

  always_comb begin
    case (forward_a)
      FWD_WB:  fwd_a = wb_fwd_data;
      FWD_MEM: fwd_a = mem_fwd_data;
      default: fwd_a = read_data_1;
    endcase
  end

  always_comb begin
    case (forward_b)
      FWD_WB:  fwd_b = wb_fwd_data;
      FWD_MEM: fwd_b = mem_fwd_data;
      default: fwd_b = read_data_2;
    endcase
  end

  assign alu_b = alu_src ? imm_ext : fwd_b;
  assign md_op = is_md_op(alu_op);

  mul_div_unit #(
    .DATA_W    (DATA_W),
    .MD_CYCLES (MD_CYCLES)
  ) u_mul_div (
    .clk         (CLK),
    .rst         (RST),
    .start       (md_op),
    .is_div      (alu_op == OP_DIV),
    .is_unsigned (shamt[0]),
    .op_a        (fwd_a),
    .op_b        (fwd_b),
    .busy        (md_busy),
    .done        (md_done),
    .hi          (hi),
    .lo          (lo)
  );

  assign stall_out = md_busy;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_ADD:  alu_y = fwd_a + alu_b;
      OP_SUB:  alu_y = fwd_a - alu_b;
      OP_AND:  alu_y = fwd_a & alu_b;
      OP_OR:   alu_y = fwd_a | alu_b;
      OP_XOR:  alu_y = fwd_a ^ alu_b;
      OP_NOR:  alu_y = ~(fwd_a | alu_b);
      OP_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      OP_SLTU: alu_y = {{(DATA_W-1){1'b0}}, (fwd_a < alu_b)};
      OP_SLL:  alu_y = alu_b << shamt;
      OP_SRL:  alu_y = alu_b >> shamt;
      OP_SRA:  alu_y = $signed(alu_b) >>> shamt;
      OP_LUI:  alu_y = alu_b << 16;
      OP_MFHI: alu_y = hi;
      OP_MFLO: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      control_wb_out <= '0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      alu_result_out <= '0;
      write_data_out <= '0;
      write_reg_out  <= '0;
    end else if (stall_out) begin
      // Bubble while the multi-cycle unit holds the pipeline.
      control_wb_out <= '0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      alu_result_out <= '0;
      write_data_out <= '0;
      write_reg_out  <= '0;
    end else begin
      // A retiring MULT/DIV only updates HI/LO, so it must not write back
      // or touch memory whatever the decoder drove.
      control_wb_out <= md_done ? 2'b00 : control_wb_in;
      mem_read_out   <= mem_read_in && !md_done;
      mem_write_out  <= mem_write_in && !md_done;
      alu_result_out <= alu_y;
      write_data_out <= fwd_b;
      write_reg_out  <= reg_dst ? rd : rt;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage with a behavioural reference model
module tb_ex_stage;
  import ex_pkg::*;

  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;
  localparam int MD_CYCLES = 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  control_wb_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] imm_ext;
  logic [4:0]  shamt;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_fwd_data;
  logic [1:0]  control_wb_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [31:0] alu_result_out;
  logic [31:0] write_data_out;
  logic [4:0]  write_reg_out;
  logic        stall_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  ex_stage #(
    .DATA_W    (DATA_W),
    .REG_W     (REG_W),
    .MD_CYCLES (MD_CYCLES)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .control_wb_in  (control_wb_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .alu_op         (alu_op),
    .alu_src        (alu_src),
    .reg_dst        (reg_dst),
    .read_data_1    (read_data_1),
    .read_data_2    (read_data_2),
    .imm_ext        (imm_ext),
    .shamt          (shamt),
    .rt             (rt),
    .rd             (rd),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .mem_fwd_data   (mem_fwd_data),
    .wb_fwd_data    (wb_fwd_data),
    .control_wb_out (control_wb_out),
    .mem_read_out   (mem_read_out),
    .mem_write_out  (mem_write_out),
    .alu_result_out (alu_result_out),
    .write_data_out (write_data_out),
    .write_reg_out  (write_reg_out),
    .stall_out      (stall_out)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    control_wb_in = 2'b00; mem_read_in = 1'b0; mem_write_in = 1'b0;
    alu_op = OP_ADD; alu_src = 1'b0; reg_dst = 1'b0;
    read_data_1 = '0; read_data_2 = '0; imm_ext = '0; shamt = '0;
    rt = '0; rd = '0; forward_a = 2'b00; forward_b = 2'b00;
    mem_fwd_data = '0; wb_fwd_data = '0;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return regv;
  endfunction

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return b << sh;
      OP_SRL:  return b >> sh;
      OP_SRA:  return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      OP_LUI:  return {b[15:0], 16'h0000};
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'h0;
    endcase
  endfunction

  task automatic md_model(input bit is_div, input bit uns, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] h, output logic [31:0] l);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      if (uns) p = {32'h0, a} * {32'h0, b};
      else     p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'h0) begin
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (uns) begin
      h = a % b;
      l = a / b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = 32'(r);
      l = 32'(q);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    control_wb_in = 2'b11; mem_read_in = 1'b1; read_data_1 = 32'h1234; rd = 5'd7; reg_dst = 1'b1;
    RST = 1'b1;
    step();
    n_checks++;
    if ({control_wb_out, mem_read_out, mem_write_out, alu_result_out, write_data_out, write_reg_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b/%b/%h/%h/%h expected all zero", control_wb_out,
               mem_read_out, mem_write_out, alu_result_out, write_data_out, write_reg_out);
    end
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b expected 0", stall_out);
    end
    RST = 1'b0;
    idle_inputs();
    alu_op = OP_MFHI;
    step();
    n_checks++;
    if (alu_result_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hi: got %h expected 00000000", alu_result_out);
    end
  endtask

  task automatic test_add_forward();
    idle_inputs();
    alu_op = OP_ADD; forward_a = 2'b10; mem_fwd_data = 32'd5; read_data_1 = 32'd99;
    read_data_2 = 32'd7; reg_dst = 1'b1; rd = 5'd3; rt = 5'd2; control_wb_in = 2'b10;
    step();
    n_checks++;
    if (alu_result_out !== 32'd12 || write_reg_out !== 5'd3 || control_wb_out !== 2'b10) begin
      n_fail++;
      $display("FAIL add_forward: got res=%h reg=%0d wb=%b expected res=0000000c reg=3 wb=10",
               alu_result_out, write_reg_out, control_wb_out);
    end
  endtask

  task automatic test_compare_shift();
    idle_inputs();
    alu_op = OP_SLT; read_data_1 = 32'hFFFF_FFFF; read_data_2 = 32'd1;
    step();
    n_checks++;
    if (alu_result_out !== 32'd1) begin
      n_fail++;
      $display("FAIL slt_signed: got %h expected 00000001", alu_result_out);
    end
    alu_op = OP_SLTU;
    step();
    n_checks++;
    if (alu_result_out !== 32'd0) begin
      n_fail++;
      $display("FAIL sltu_unsigned: got %h expected 00000000", alu_result_out);
    end
    alu_op = OP_SRA; read_data_2 = 32'h8000_0000; shamt = 5'd4;
    step();
    n_checks++;
    if (alu_result_out !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL sra: got %h expected f8000000", alu_result_out);
    end
  endtask

  task automatic test_store();
    idle_inputs();
    alu_op = OP_ADD; alu_src = 1'b1; imm_ext = 32'h10; read_data_1 = 32'h100;
    read_data_2 = 32'h55; forward_b = 2'b01; wb_fwd_data = 32'hAB;
    mem_write_in = 1'b1; control_wb_in = 2'b00;
    step();
    n_checks++;
    if (write_data_out !== 32'hAB || mem_write_out !== 1'b1 || control_wb_out !== 2'b00 ||
        alu_result_out !== 32'h110) begin
      n_fail++;
      $display("FAIL store: got wd=%h mw=%b wb=%b addr=%h expected wd=000000ab mw=1 wb=00 addr=00000110",
               write_data_out, mem_write_out, control_wb_out, alu_result_out);
    end
  endtask

  task automatic test_random_alu(input int n);
    logic [31:0] a;
    logic [31:0] bf;
    logic [31:0] b;
    logic [72:0] exp_v;
    logic [72:0] got_v;
    for (int i = 0; i < n; i++) begin
      alu_op = 4'($urandom_range(0, 13));
      control_wb_in = 2'($urandom_range(0, 3));
      mem_read_in = 1'($urandom_range(0, 1));
      mem_write_in = 1'($urandom_range(0, 1));
      alu_src = 1'($urandom_range(0, 1));
      reg_dst = 1'($urandom_range(0, 1));
      read_data_1 = $urandom; read_data_2 = $urandom; imm_ext = $urandom;
      shamt = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31)); rd = 5'($urandom_range(0, 31));
      forward_a = 2'($urandom_range(0, 3)); forward_b = 2'($urandom_range(0, 3));
      mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      a  = pick(forward_a, read_data_1, wb_fwd_data, mem_fwd_data);
      bf = pick(forward_b, read_data_2, wb_fwd_data, mem_fwd_data);
      b  = alu_src ? imm_ext : bf;
      exp_v = {control_wb_in, mem_read_in, mem_write_in, alu_model(alu_op, a, b, shamt), bf,
               reg_dst ? rd : rt};
      step();
      got_v = {control_wb_out, mem_read_out, mem_write_out, alu_result_out, write_data_out,
               write_reg_out};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rand_alu[%0d] op=%0d: got %h expected %h", i, alu_op, got_v, exp_v);
      end
    end
  endtask

  task automatic test_md_sequence(input bit is_div, input bit uns, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp_hi,
                                  input logic [31:0] exp_lo);
    int stalls;
    int bubble_bad;
    idle_inputs();
    alu_op = is_div ? OP_DIV : OP_MULT; shamt = {4'b0000, uns};
    read_data_1 = a; read_data_2 = b; control_wb_in = 2'b11; mem_read_in = 1'b1;
    mem_write_in = 1'b1; rd = 5'd9; rt = 5'd8; reg_dst = 1'b1;
    #1;
    stalls = 0;
    bubble_bad = 0;
    while (stall_out === 1'b1 && stalls < 200) begin
      step();
      stalls++;
      if ({control_wb_out, mem_read_out, mem_write_out, alu_result_out, write_data_out,
           write_reg_out} !== '0) bubble_bad++;
      // Operands must already be captured; disturb the sources.
      read_data_1 = $urandom; read_data_2 = $urandom;
      mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      #1;
    end
    n_checks++;
    if (stalls != MD_CYCLES + 1) begin
      n_fail++;
      $display("FAIL md_stall_cycles div=%0b: got %0d expected %0d", is_div, stalls, MD_CYCLES + 1);
    end
    n_checks++;
    if (bubble_bad != 0) begin
      n_fail++;
      $display("FAIL md_bubble div=%0b: got %0d non-bubble cycles expected 0", is_div, bubble_bad);
    end
    step();
    n_checks++;
    if ({control_wb_out, mem_read_out, mem_write_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL md_retire_ctrl: got %b%b%b expected 0000", control_wb_out, mem_read_out,
               mem_write_out);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
    alu_op = OP_MFHI; shamt = '0; control_wb_in = 2'b10; mem_read_in = 1'b0; mem_write_in = 1'b0;
    step();
    n_checks++;
    if (alu_result_out !== m_hi) begin
      n_fail++;
      $display("FAIL md_hi a=%h b=%h div=%0b uns=%0b: got %h expected %h", a, b, is_div, uns,
               alu_result_out, m_hi);
    end
    alu_op = OP_MFLO;
    step();
    n_checks++;
    if (alu_result_out !== m_lo) begin
      n_fail++;
      $display("FAIL md_lo a=%h b=%h div=%0b uns=%0b: got %h expected %h", a, b, is_div, uns,
               alu_result_out, m_lo);
    end
  endtask

  task automatic test_random_md(input int n);
    bit          is_div;
    bit          uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
    for (int k = 0; k < n; k++) begin
      is_div = 1'($urandom_range(0, 1));
      uns    = 1'($urandom_range(0, 1));
      a      = $urandom;
      case (k % 4)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      md_model(is_div, uns, a, b, h, l);
      test_md_sequence(is_div, uns, a, b, h, l);
    end
  endtask

  task automatic test_reset_mid_op();
    idle_inputs();
    alu_op = OP_MULT; read_data_1 = 32'h1234_5678; read_data_2 = 32'h9;
    #1;
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy: got stall %b expected 1", stall_out);
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (stall_out !== 1'b0 || {control_wb_out, mem_read_out, mem_write_out, alu_result_out,
                               write_data_out, write_reg_out} !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got stall=%b res=%h wb=%b expected stall=0 all zero",
               stall_out, alu_result_out, control_wb_out);
    end
    idle_inputs();
    alu_op = OP_ADD; read_data_1 = 32'd1; read_data_2 = 32'd1; reg_dst = 1'b1; rd = 5'd4;
    control_wb_in = 2'b10;
    #1;
    RST = 1'b0;
    m_hi = '0;
    m_lo = '0;
    step();
    n_checks++;
    if (alu_result_out !== 32'd2 || write_reg_out !== 5'd4 || control_wb_out !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_add: got res=%h reg=%0d wb=%b expected res=00000002 reg=4 wb=10",
               alu_result_out, write_reg_out, control_wb_out);
    end
    alu_op = OP_MFHI;
    step();
    n_checks++;
    if (alu_result_out !== m_hi) begin
      n_fail++;
      $display("FAIL midrst_hi: got %h expected %h", alu_result_out, m_hi);
    end
    alu_op = OP_MFLO;
    step();
    n_checks++;
    if (alu_result_out !== m_lo) begin
      n_fail++;
      $display("FAIL midrst_lo: got %h expected %h", alu_result_out, m_lo);
    end
  endtask

  initial begin
    test_reset();
    test_add_forward();
    test_compare_shift();
    test_store();
    test_random_alu(60);
    test_md_sequence(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_md_sequence(1'b1, 1'b0, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    test_md_sequence(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_md_sequence(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    test_md_sequence(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_random_md(8);
    test_random_alu(20);
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
